// File: rtl/capture_ctrl.sv
// Sample-capture controller: ring-buffer writes while armed, post-trigger delay,
// then newest-first readback of the captured window over a valid/ready handshake.
module capture_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cmd_i,
  input  logic              set_cnt_i,
  input  logic              arm_i,
  input  logic              clr_i,
  input  logic              run_i,
  input  logic              stb_i,
  input  logic [31:0]       smpls_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic [31:0]       rdata_i,
  output logic [31:0]       tx_data_o,
  output logic              tx_vld_o,
  input  logic              tx_rdy_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  // (0xFFFF + 1) * 4 needs 19 bits, so counts are one bit wider than 18.
  localparam int CNT_W = 19;

  typedef enum logic [2:0] {
    IDLE, ARMED, DELAY, RD_REQ, RD_WAIT, RD_SEND
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  read_n_q, delay_n_q;
  logic [CNT_W-1:0]  rlim_q, dlim_q, dcnt_q, rcnt_q;
  logic [CNT_W-1:0]  read_calc, delay_calc, read_clamp;
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [31:0]       tx_data_q;
  logic              tx_vld_q, done_q;
  logic              last_delay, xfer, last_word;

  assign read_calc  = (CNT_W'(cmd_i[15:0]) + CNT_W'(1)) << 2;
  assign delay_calc = (CNT_W'(cmd_i[31:16]) + CNT_W'(1)) << 2;
  assign read_clamp = (read_calc > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : read_calc;

  assign we_o      = stb_i && (state_q == ARMED || state_q == DELAY);
  assign waddr_o   = wptr_q;
  assign wdata_o   = smpls_i;
  assign raddr_o   = rptr_q;
  assign tx_data_o = tx_data_q;
  assign tx_vld_o  = tx_vld_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != IDLE);

  assign last_delay = (state_q == DELAY) && stb_i && (dcnt_q + CNT_W'(1) == dlim_q);
  assign xfer       = (state_q == RD_SEND) && tx_vld_q && tx_rdy_i;
  assign last_word  = xfer && (rcnt_q + CNT_W'(1) == rlim_q);

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm_i) state_d = ARMED;
        ARMED:   if (run_i) state_d = DELAY;
        DELAY:   if (last_delay) state_d = RD_REQ;
        RD_REQ:  state_d = RD_WAIT;
        RD_WAIT: state_d = RD_SEND;
        RD_SEND: if (xfer) state_d = last_word ? IDLE : RD_REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Programmed counts survive the soft reset; only the hard reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_n_q  <= '0;
      delay_n_q <= '0;
    end else if (set_cnt_i && !clr_i) begin
      read_n_q  <= read_clamp;
      delay_n_q <= delay_calc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      dlim_q    <= '0;
      rlim_q    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      done_q    <= 1'b0;
    end else if (clr_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      dlim_q    <= '0;
      rlim_q    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (we_o) wptr_q <= wptr_q + ADDR_W'(1);
      case (state_q)
        ARMED: if (run_i) begin
          dcnt_q <= '0;
          dlim_q <= delay_n_q;
        end
        DELAY: if (stb_i) begin
          dcnt_q <= dcnt_q + CNT_W'(1);
          if (last_delay) begin
            // Newest sample is the one being written this cycle.
            rptr_q <= wptr_q;
            rcnt_q <= '0;
            rlim_q <= read_n_q;
          end
        end
        RD_WAIT: begin
          tx_data_q <= rdata_i;
          tx_vld_q  <= 1'b1;
        end
        RD_SEND: if (xfer) begin
          rcnt_q   <= rcnt_q + CNT_W'(1);
          rptr_q   <= rptr_q - ADDR_W'(1);
          tx_vld_q <= 1'b0;
          done_q   <= last_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ADDR_W=4 and a behavioural sample RAM
// (one-cycle read latency); expected words are hand-computed per step.
module tb_capture_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   cmd = '0;
  logic          set_cnt = 1'b0, arm = 1'b0, clr = 1'b0, run = 1'b0, stb = 1'b0;
  logic [31:0]   smpls = '0;
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [31:0]   wdata, rdata, tx_data;
  logic          tx_vld, busy, done;
  logic          tx_rdy = 1'b1;

  logic [31:0]   mem [16];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_i(cmd), .set_cnt_i(set_cnt), .arm_i(arm),
    .clr_i(clr), .run_i(run), .stb_i(stb), .smpls_i(smpls),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .raddr_o(raddr), .rdata_i(rdata),
    .tx_data_o(tx_data), .tx_vld_o(tx_vld), .tx_rdy_i(tx_rdy),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects n words top, top-1, ...; optionally stalls tx_rdy for 5 cycles on word stall_at.
  task automatic read_block(input int n, input int top, input int stall_at);
    int seen;
    int d0;
    logic [AW-1:0] hold_a;
    d0 = done_cnt;
    for (int k = 0; k < n; k++) begin
      seen = 0;
      for (int t = 0; t < 8 && seen == 0; t++) begin
        if (tx_vld) seen = 1;
        else tick();
      end
      if (seen == 0) begin
        check("vld_timeout", tx_vld, 1);
        return;
      end
      check("tx_data", tx_data, top - k);
      check("we_in_rd", we, 0);
      if (k == stall_at) begin
        tx_rdy = 1'b0;
        hold_a = raddr;
        repeat (5) begin
          tick();
          check("stall_vld", tx_vld, 1);
          check("stall_data", tx_data, top - k);
          check("stall_raddr", raddr, hold_a);
        end
        tx_rdy = 1'b1;
      end
      tick();
      if (k == n - 1) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
      end else begin
        check("vld_drop", tx_vld, 0);
      end
    end
    tick();
    check("done_once", done_cnt - d0, 1);
    check("done_low", done, 0);
    check("vld_idle", tx_vld, 0);
  endtask

  initial begin
    int seen;
    int d0;

    #1 rst = 1'b1;
    #11;
    check("rst_busy", busy, 0);
    check("rst_vld", tx_vld, 0);
    check("rst_we", we, 0);
    check("rst_done", done, 0);
    check("rst_txdata", tx_data, 0);
    check("rst_raddr", raddr, 0);
    check("rst_waddr", waddr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic capture: read 4, delay 4, trigger on sample 6.
    cmd = 32'h0000_0000; set_cnt = 1'b1; tick(); set_cnt = 1'b0;
    run = 1'b1; stb = 1'b1; smpls = 32'd5; #1;
    check("idle_we", we, 0);
    tick();
    check("idle_run_busy", busy, 0);
    check("idle_waddr", waddr, 0);
    run = 1'b0; stb = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    check("armed_busy", busy, 1);
    for (int i = 1; i <= 10; i++) begin
      smpls = i; stb = 1'b1; run = (i == 6); #1;
      check("cap_we", we, 1);
      check("cap_waddr", waddr, i - 1);
      tick();
    end
    run = 1'b0; smpls = 32'd99; stb = 1'b1; #1;
    check("rdreq_raddr", raddr, 9);
    check("rdreq_we", we, 0);
    check("rdreq_busy", busy, 1);
    read_block(4, 10, -1);
    check("post_waddr", waddr, 10);
    stb = 1'b0;

    // Wrap-around: read 16, delay 4, 20 pre-trigger samples; arm while armed is ignored.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_waddr", waddr, 0);
    cmd = 32'h0000_0003; set_cnt = 1'b1; arm = 1'b1; tick(); set_cnt = 1'b0; arm = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      smpls = i; stb = 1'b1; arm = (i == 5); tick();
    end
    stb = 1'b0; arm = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 21; i <= 24; i++) begin
      smpls = i; stb = 1'b1; tick();
    end
    stb = 1'b0;
    read_block(16, 24, -1);

    // Clamp to DEPTH plus backpressure on the third word.
    clr = 1'b1; tick(); clr = 1'b0;
    cmd = 32'h0000_00FF; set_cnt = 1'b1; tick(); set_cnt = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      smpls = 200 + i; stb = 1'b1; tick();
    end
    stb = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 17; i <= 20; i++) begin
      smpls = 200 + i; stb = 1'b1; tick();
    end
    stb = 1'b0;
    read_block(16, 220, 2);

    // clr in DELAY returns to IDLE; programmed counts (delay 8, read 4) survive.
    clr = 1'b1; tick(); clr = 1'b0;
    cmd = 32'h0001_0000; set_cnt = 1'b1; tick(); set_cnt = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    smpls = 32'd0; stb = 1'b1; tick(); tick(); stb = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_delay_busy", busy, 0);
    check("clr_delay_waddr", waddr, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      smpls = 300 + i; stb = 1'b1; #1;
      check("delay8_we", we, 1);
      tick();
    end
    #1;
    check("delay8_end_we", we, 0);
    check("delay8_end_busy", busy, 1);
    stb = 1'b0;
    read_block(4, 308, -1);

    // Asynchronous reset while a word is waiting in RD_SEND.
    cmd = 32'h0000_0000; set_cnt = 1'b1; tick(); set_cnt = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      smpls = 400 + i; stb = 1'b1; tick();
    end
    stb = 1'b0;
    tx_rdy = 1'b0;
    seen = 0;
    for (int t = 0; t < 8 && seen == 0; t++) begin
      if (tx_vld) seen = 1;
      else tick();
    end
    check("rst_mid_vld_seen", tx_vld, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_vld", tx_vld, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_txdata", tx_data, 0);
    d0 = done_cnt;
    tick(); tick();
    check("rst_mid_done", done, 0);
    check("rst_mid_no_done", done_cnt - d0, 0);
    rst = 1'b0; tx_rdy = 1'b1;
    tick();
    check("rst_mid_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
